// File: rtl/step_seq_counter_if.sv
// rtl/step_seq_counter_if.sv - control/status bundle of the step sequence counter (STEP_SEQ_PRESCALE_EN adds prescale)
interface step_seq_counter_if #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
);
  logic             clr;
  logic             tick;
  logic [1:0]       mode;
  logic [WIDTH-1:0] steps;
`ifdef STEP_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale;
`endif
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             wrap;
  logic             done;

`ifdef STEP_SEQ_PRESCALE_EN
  modport master (output clr, tick, mode, steps, prescale, input count, dir, wrap, done);
  modport slave  (input clr, tick, mode, steps, prescale, output count, dir, wrap, done);
`else
  modport master (output clr, tick, mode, steps, input count, dir, wrap, done);
  modport slave  (input clr, tick, mode, steps, output count, dir, wrap, done);
`endif
endinterface

// File: rtl/step_seq_counter.sv
// rtl/step_seq_counter.sv - tick-driven step position counter, four modes (STEP_SEQ_PRESCALE_EN adds prescaler)
module step_seq_counter #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  step_seq_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_PING    = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  logic             r_tick_q;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_wrap;
  logic             r_done;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_dir_nxt;
  logic             w_wrap_nxt;
  logic             w_done_nxt;
  logic             w_event;
  logic             w_advance;
  logic             w_at_top;
  logic             w_above;
  logic             w_at_zero;
  mode_e            w_mode;

  assign w_mode    = mode_e'(bus.mode);
  assign w_event   = bus.tick & ~r_tick_q;
  // A lowered steps leaves count above it; treat that as sitting on the terminal value.
  assign w_at_top  = (r_count >= bus.steps);
  assign w_above   = (r_count > bus.steps);
  assign w_at_zero = (r_count == '0);

`ifdef STEP_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] r_pre;
  logic                  w_pre_hit;

  assign w_pre_hit = (r_pre == bus.prescale);
  assign w_advance = w_event & w_pre_hit;

  // Count tick events; only every (prescale+1)-th one advances the step position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (bus.clr) begin
      r_pre <= '0;
    end else if (w_event) begin
      r_pre <= w_pre_hit ? '0 : r_pre + PRESCALE_W'(1);
    end
  end
`else
  assign w_advance = w_event;
`endif

  // Next-state selection: clear first, then one step of the active mode on an advance.
  always_comb begin
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_wrap_nxt  = 1'b0;
    w_done_nxt  = (w_mode == MODE_ONESHOT) ? r_done : 1'b0;
    if (bus.clr) begin
      w_count_nxt = (w_mode == MODE_DOWN) ? bus.steps : '0;
      w_dir_nxt   = (w_mode == MODE_DOWN);
      w_done_nxt  = 1'b0;
    end else if (w_advance) begin
      if (bus.steps == '0) begin
        w_count_nxt = '0;
        if (w_mode == MODE_ONESHOT) w_done_nxt = 1'b1;
      end else begin
        case (w_mode)
          MODE_UP: begin
            w_dir_nxt = 1'b0;
            if (w_at_top) begin
              w_count_nxt = '0;
              w_wrap_nxt  = 1'b1;
            end else begin
              w_count_nxt = r_count + WIDTH'(1);
            end
          end
          MODE_DOWN: begin
            w_dir_nxt = 1'b1;
            if (w_at_zero) begin
              w_count_nxt = bus.steps;
              w_wrap_nxt  = 1'b1;
            end else if (w_above) begin
              w_count_nxt = bus.steps - WIDTH'(1);
            end else begin
              w_count_nxt = r_count - WIDTH'(1);
            end
          end
          MODE_PING: begin
            if (!r_dir) begin
              if (w_at_top) begin
                w_dir_nxt   = 1'b1;
                w_count_nxt = bus.steps - WIDTH'(1);
                w_wrap_nxt  = 1'b1;
              end else begin
                w_count_nxt = r_count + WIDTH'(1);
              end
            end else begin
              if (w_at_zero) begin
                w_dir_nxt   = 1'b0;
                w_count_nxt = WIDTH'(1);
                w_wrap_nxt  = 1'b1;
              end else if (w_above) begin
                w_count_nxt = bus.steps - WIDTH'(1);
              end else begin
                w_count_nxt = r_count - WIDTH'(1);
              end
            end
          end
          default: begin
            w_dir_nxt = 1'b0;
            if (!r_done) begin
              if (w_at_top) begin
                w_count_nxt = bus.steps;
                w_done_nxt  = 1'b1;
              end else begin
                w_count_nxt = r_count + WIDTH'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // State register; tick_q samples tick every cycle, including during clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_q <= 1'b0;
      r_count  <= '0;
      r_dir    <= 1'b0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tick_q <= bus.tick;
      r_count  <= w_count_nxt;
      r_dir    <= w_dir_nxt;
      r_wrap   <= w_wrap_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.count = r_count;
  assign bus.dir   = r_dir;
  assign bus.wrap  = r_wrap;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_step_seq_counter.sv
// tb/tb_step_seq_counter.sv - directed bench for step_seq_counter
module tb_step_seq_counter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  step_seq_counter_if #(.WIDTH(4), .PRESCALE_W(4)) bus ();

  step_seq_counter #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick_pulse();
    @(negedge clk) bus.tick = 1'b1;
    @(negedge clk) bus.tick = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk) bus.clr = 1'b1;
    @(negedge clk) bus.clr = 1'b0;
  endtask

  initial begin
    int up_cnt[8]   = '{1, 2, 3, 4, 5, 0, 1, 2};
    int up_wrp[8]   = '{0, 0, 0, 0, 0, 1, 0, 0};
    int dn_cnt[4]   = '{2, 1, 0, 3};
    int dn_wrp[4]   = '{0, 0, 0, 1};
    int pp_cnt[8]   = '{1, 2, 3, 2, 1, 0, 1, 2};
    int pp_wrp[8]   = '{0, 0, 0, 1, 0, 0, 1, 0};
    int pp_dir[8]   = '{0, 0, 0, 1, 1, 1, 0, 0};
    int os_cnt[5]   = '{1, 2, 2, 2, 2};
    int os_done[5]  = '{0, 0, 1, 1, 1};

    n_cmp       = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.clr     = 1'b0;
    bus.tick    = 1'b0;
    bus.mode    = 2'b00;
    bus.steps   = 4'd5;
`ifdef STEP_SEQ_PRESCALE_EN
    bus.prescale = '0;
`endif

    #1 rst = 1'b1;
    #1;
    check("rst_count", 32'(bus.count), 0);
    check("rst_dir",   32'(bus.dir),   0);
    check("rst_wrap",  32'(bus.wrap),  0);
    check("rst_done",  32'(bus.done),  0);
    @(negedge clk) rst = 1'b0;

    // up-wrap, steps 5
    for (int i = 0; i < 8; i++) begin
      tick_pulse();
      check($sformatf("up_count[%0d]", i), 32'(bus.count), 32'(up_cnt[i]));
      check($sformatf("up_wrap[%0d]", i),  32'(bus.wrap),  32'(up_wrp[i]));
    end

    // down-wrap, steps 3
    bus.mode  = 2'b01;
    bus.steps = 4'd3;
    do_clr();
    check("dn_clr_count", 32'(bus.count), 3);
    check("dn_clr_dir",   32'(bus.dir),   1);
    for (int i = 0; i < 4; i++) begin
      tick_pulse();
      check($sformatf("dn_count[%0d]", i), 32'(bus.count), 32'(dn_cnt[i]));
      check($sformatf("dn_wrap[%0d]", i),  32'(bus.wrap),  32'(dn_wrp[i]));
    end

    // ping-pong, steps 3
    bus.mode = 2'b10;
    do_clr();
    check("pp_clr_count", 32'(bus.count), 0);
    for (int i = 0; i < 8; i++) begin
      tick_pulse();
      check($sformatf("pp_count[%0d]", i), 32'(bus.count), 32'(pp_cnt[i]));
      check($sformatf("pp_wrap[%0d]", i),  32'(bus.wrap),  32'(pp_wrp[i]));
      check($sformatf("pp_dir[%0d]", i),   32'(bus.dir),   32'(pp_dir[i]));
    end

    // one-shot, steps 2
    bus.mode  = 2'b11;
    bus.steps = 4'd2;
    do_clr();
    for (int i = 0; i < 5; i++) begin
      tick_pulse();
      check($sformatf("os_count[%0d]", i), 32'(bus.count), 32'(os_cnt[i]));
      check($sformatf("os_done[%0d]", i),  32'(bus.done),  32'(os_done[i]));
      check($sformatf("os_wrap[%0d]", i),  32'(bus.wrap),  0);
    end
    do_clr();
    check("os_clr_count", 32'(bus.count), 0);
    check("os_clr_done",  32'(bus.done),  0);

    // steps 0 in up-wrap and down-wrap
    bus.mode  = 2'b00;
    bus.steps = 4'd0;
    do_clr();
    for (int i = 0; i < 3; i++) begin
      tick_pulse();
      check($sformatf("z_up_count[%0d]", i), 32'(bus.count), 0);
      check($sformatf("z_up_wrap[%0d]", i),  32'(bus.wrap),  0);
    end
    bus.mode = 2'b01;
    do_clr();
    for (int i = 0; i < 3; i++) begin
      tick_pulse();
      check($sformatf("z_dn_count[%0d]", i), 32'(bus.count), 0);
      check($sformatf("z_dn_wrap[%0d]", i),  32'(bus.wrap),  0);
    end

    // held tick advances once; lowered steps then wraps
    bus.mode  = 2'b00;
    bus.steps = 4'd8;
    do_clr();
    repeat (3) tick_pulse();
    check("hold_pre_count", 32'(bus.count), 3);
    @(negedge clk) bus.tick = 1'b1;
    repeat (10) @(negedge clk);
    check("hold_count", 32'(bus.count), 4);
    bus.tick  = 1'b0;
    bus.steps = 4'd2;
    @(negedge clk);
    check("lowered_hold_count", 32'(bus.count), 4);
    tick_pulse();
    check("lowered_count", 32'(bus.count), 0);
    check("lowered_wrap",  32'(bus.wrap),  1);
    @(negedge clk);
    check("lowered_wrap_gone", 32'(bus.wrap), 0);

    // asynchronous reset between edges
    bus.steps = 4'd8;
    do_clr();
    repeat (3) tick_pulse();
    check("arst_pre_count", 32'(bus.count), 3);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_count", 32'(bus.count), 0);
    check("arst_dir",   32'(bus.dir),   0);
    check("arst_wrap",  32'(bus.wrap),  0);
    check("arst_done",  32'(bus.done),  0);
    @(negedge clk) rst = 1'b0;
    tick_pulse();
    check("post_rst_count", 32'(bus.count), 1);

    // clr and tick event on the same edge
    @(negedge clk) begin
      bus.clr  = 1'b1;
      bus.tick = 1'b1;
    end
    @(negedge clk) begin
      bus.clr  = 1'b0;
      bus.tick = 1'b0;
    end
    check("clr_tick_count", 32'(bus.count), 0);
    check("clr_tick_wrap",  32'(bus.wrap),  0);
    tick_pulse();
    check("after_clr_count", 32'(bus.count), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
